// File: rtl/conv_pkg.sv
// Shared types and constants for the convolution sequencer.
// Holds the FSM state encoding, counter width and filter tap count.
package conv_pkg;

    localparam int ADDR_FIFO = 8;
    localparam int FILT_TAPS = 9;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_FILT,
        CLR,
        STREAM,
        DRAIN,
        DONE
    } state_t;

endpackage

// File: rtl/conv_pos_counter.sv
// Column/row position tracker for the pixel stream.
// Column wraps at row_length-1 and bumps the row; last flags the final pixel.
module conv_pos_counter
    import conv_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 advance,
    input  logic [ADDR_FIFO-1:0] row_length,
    input  logic [ADDR_FIFO-1:0] num_rows,
    output logic [ADDR_FIFO-1:0] column,
    output logic [ADDR_FIFO-1:0] row,
    output logic                 last
);

    localparam logic [ADDR_FIFO-1:0] ONE = ADDR_FIFO'(1);

    logic col_end;

    assign col_end = (column == row_length - ONE);
    assign last    = col_end && (row == num_rows - ONE);

    // Step the position on each accepted pixel, wrapping at end of row.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            column <= '0;
            row    <= '0;
        end else if (clear) begin
            column <= '0;
            row    <= '0;
        end else if (advance) begin
            if (col_end) begin
                column <= '0;
                row    <= row + ONE;
            end else begin
                column <= column + ONE;
            end
        end
    end

endmodule

// File: rtl/conv_sequencer.sv
// Control sequencer for a 3x3 line-buffer convolver.
// Loads 9 filter words, clears the line buffer, streams an image, drains the MAC.
module conv_sequencer
    import conv_pkg::*;
#(
    parameter int MAC_LATENCY = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [ADDR_FIFO-1:0] row_length,
    input  logic [ADDR_FIFO-1:0] num_rows,
    input  logic                 filt_valid,
    output logic                 filt_ready,
    input  logic                 pix_valid,
    output logic                 pix_ready,
    output logic                 shifting_filter,
    output logic                 shifting_line,
    output logic                 line_buffer_reset,
    output logic                 mac_enable,
    output logic                 out_valid,
    output logic                 busy,
    output logic                 done,
    output logic                 cfg_err
);

    localparam logic [ADDR_FIFO-1:0] MIN_DIM = ADDR_FIFO'(3);
    localparam logic [ADDR_FIFO-1:0] EDGE    = ADDR_FIFO'(2);

    state_t                 state;
    state_t                 next;
    logic [ADDR_FIFO-1:0]   rl_q;
    logic [ADDR_FIFO-1:0]   nr_q;
    logic [ADDR_FIFO-1:0]   column;
    logic [ADDR_FIFO-1:0]   row;
    logic                   last;
    logic [3:0]             filt_cnt;
    logic [7:0]             drain_cnt;
    logic                   err_q;
    logic                   mac_q;
    logic [MAC_LATENCY-1:0] dly;
    logic                   accept;
    logic                   start_ok;
    logic                   bad_cfg;

    assign accept     = (state == STREAM) && pix_valid;
    assign start_ok   = (state == IDLE) && start;
    assign bad_cfg    = (row_length < MIN_DIM) || (num_rows < MIN_DIM);
    assign mac_enable = mac_q;
    assign out_valid  = dly[MAC_LATENCY-1];
    assign cfg_err    = done && err_q;

    conv_pos_counter u_pos (
        .clk        (clk),
        .rst        (rst),
        .clear      (state == CLR),
        .advance    (accept),
        .row_length (rl_q),
        .num_rows   (nr_q),
        .column     (column),
        .row        (row),
        .last       (last)
    );

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= next;
    end

    // Next-state logic and per-state control outputs.
    always_comb begin
        next              = state;
        filt_ready        = 1'b0;
        shifting_filter   = 1'b0;
        line_buffer_reset = 1'b0;
        pix_ready         = 1'b0;
        shifting_line     = 1'b0;
        busy              = 1'b1;
        done              = 1'b0;
        unique case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) next = bad_cfg ? DONE : LOAD_FILT;
            end
            LOAD_FILT: begin
                filt_ready      = 1'b1;
                shifting_filter = filt_valid;
                if (filt_valid && filt_cnt == 4'(FILT_TAPS - 1))
                    next = CLR;
            end
            CLR: begin
                line_buffer_reset = 1'b1;
                next              = STREAM;
            end
            STREAM: begin
                pix_ready     = 1'b1;
                shifting_line = pix_valid;
                if (pix_valid && last) next = DRAIN;
            end
            DRAIN: begin
                if (drain_cnt == 8'(MAC_LATENCY)) next = DONE;
            end
            DONE: begin
                done = 1'b1;
                next = IDLE;
            end
            default: next = IDLE;
        endcase
    end

    // Job configuration capture, filter/drain counting and MAC enable.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rl_q      <= '0;
            nr_q      <= '0;
            err_q     <= 1'b0;
            filt_cnt  <= '0;
            drain_cnt <= '0;
            mac_q     <= 1'b0;
        end else begin
            if (start_ok) begin
                rl_q  <= row_length;
                nr_q  <= num_rows;
                err_q <= bad_cfg;
            end
            if (state == LOAD_FILT && filt_valid) begin
                if (filt_cnt == 4'(FILT_TAPS - 1)) filt_cnt <= '0;
                else                               filt_cnt <= filt_cnt + 4'd1;
            end
            if (state == DRAIN) drain_cnt <= drain_cnt + 8'd1;
            else                drain_cnt <= '0;
            mac_q <= accept && (column >= EDGE) && (row >= EDGE);
        end
    end

    // MAC pipeline delay line producing out_valid.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dly <= '0;
        end else begin
            dly[0] <= mac_q;
            for (int i = 1; i < MAC_LATENCY; i++) dly[i] <= dly[i-1];
        end
    end

endmodule

// File: tb/tb_conv_sequencer.sv
// Directed testbench for conv_sequencer.
// Runs a latency-1 and a latency-3 instance side by side on shared stimulus.
module tb_conv_sequencer;
    import conv_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0;
    logic filt_valid = 1'b0;
    logic pix_valid = 1'b0;
    logic [ADDR_FIFO-1:0] row_length = '0;
    logic [ADDR_FIFO-1:0] num_rows = '0;

    logic filt_ready, pix_ready, shifting_filter, shifting_line;
    logic line_buffer_reset, mac_enable, out_valid, busy, done, cfg_err;
    logic filt_ready3, pix_ready3, shifting_filter3, shifting_line3;
    logic line_buffer_reset3, mac_enable3, out_valid3, busy3, done3, cfg_err3;

    int n_cmp = 0;
    int n_bad = 0;

    int n_out, n_out3, n_sf, n_lbr, n_acc, n_done, n_err, n_errdone;
    int gap_viol, lat_viol, t_last, t_lastout, t_done, t_done3;
    bit timeout, aborted, prev_acc;
    logic [2:0] mh;

    conv_sequencer #(.MAC_LATENCY(1)) dut (
        .clk(clk), .rst(rst), .start(start),
        .row_length(row_length), .num_rows(num_rows),
        .filt_valid(filt_valid), .filt_ready(filt_ready),
        .pix_valid(pix_valid), .pix_ready(pix_ready),
        .shifting_filter(shifting_filter), .shifting_line(shifting_line),
        .line_buffer_reset(line_buffer_reset), .mac_enable(mac_enable),
        .out_valid(out_valid), .busy(busy), .done(done), .cfg_err(cfg_err)
    );

    conv_sequencer #(.MAC_LATENCY(3)) dut3 (
        .clk(clk), .rst(rst), .start(start),
        .row_length(row_length), .num_rows(num_rows),
        .filt_valid(filt_valid), .filt_ready(filt_ready3),
        .pix_valid(pix_valid), .pix_ready(pix_ready3),
        .shifting_filter(shifting_filter3), .shifting_line(shifting_line3),
        .line_buffer_reset(line_buffer_reset3), .mac_enable(mac_enable3),
        .out_valid(out_valid3), .busy(busy3), .done(done3), .cfg_err(cfg_err3)
    );

    always #5 clk = ~clk;

    task automatic run_job(input int rl, input int nr, input bit tog,
                           input bit mid, input int abort_n);
        int c;
        n_out = 0; n_out3 = 0; n_sf = 0; n_lbr = 0; n_acc = 0;
        n_done = 0; n_err = 0; n_errdone = 0; gap_viol = 0; lat_viol = 0;
        t_last = -1; t_lastout = -1; t_done = -1; t_done3 = -1;
        timeout = 0; aborted = 0; prev_acc = 0; mh = '0;
        row_length = ADDR_FIFO'(rl);
        num_rows = ADDR_FIFO'(nr);
        start = 1'b1;
        filt_valid = 1'b1;
        pix_valid = 1'b1;
        c = 0;
        while (1) begin
            #1;
            if (pix_valid && pix_ready) begin
                n_acc++;
                if (n_acc == rl * nr) t_last = c;
            end
            if (mac_enable && !prev_acc) gap_viol++;
            prev_acc = pix_valid && pix_ready;
            if (out_valid) begin n_out++; t_lastout = c; end
            if (out_valid3) n_out3++;
            if (out_valid3 !== mh[2]) lat_viol++;
            mh = {mh[1:0], mac_enable3};
            if (shifting_filter) n_sf++;
            if (line_buffer_reset) n_lbr++;
            if (done) begin n_done++; t_done = c; end
            if (done3) t_done3 = c;
            if (cfg_err) n_err++;
            if (cfg_err && done) n_errdone++;
            if (abort_n > 0 && n_acc == abort_n) begin
                rst = 1'b0;
                aborted = 1;
                break;
            end
            if (c > 1 && !busy && !busy3) break;
            if (c > 400) begin timeout = 1; break; end
            @(posedge clk);
            c++;
            #1;
            start = mid && pix_ready;
            if (tog) pix_valid = !pix_valid;
            if (mid && pix_ready) begin
                row_length = ADDR_FIFO'(9);
                num_rows = ADDR_FIFO'(9);
            end
        end
        start = 1'b0;
        filt_valid = 1'b0;
        pix_valid = 1'b0;
    endtask

    task automatic test_reset();
        logic [9:0] o1, o3;
        rst = 1'b0;
        start = 1'b1;
        filt_valid = 1'b1;
        pix_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        o1 = {filt_ready, pix_ready, shifting_filter, shifting_line,
              line_buffer_reset, mac_enable, out_valid, busy, done, cfg_err};
        o3 = {filt_ready3, pix_ready3, shifting_filter3, shifting_line3,
              line_buffer_reset3, mac_enable3, out_valid3, busy3, done3, cfg_err3};
        n_cmp++;
        if (o1 !== 10'b0) begin
            n_bad++;
            $display("FAIL reset_outputs: got %b expected 0", o1);
        end
        n_cmp++;
        if (o3 !== 10'b0) begin
            n_bad++;
            $display("FAIL reset_outputs3: got %b expected 0", o3);
        end
        start = 1'b0;
        filt_valid = 1'b0;
        pix_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_idle_busy: got %b expected 0", busy);
        end
    endtask

    task automatic test_back_to_back();
        run_job(5, 5, 0, 0, 0);
        n_cmp++;
        if (timeout) begin n_bad++; $display("FAIL b2b_timeout: got 1 expected 0"); end
        n_cmp++;
        if (n_out != 9) begin n_bad++; $display("FAIL b2b_out: got %0d expected 9", n_out); end
        n_cmp++;
        if (n_out3 != 9) begin n_bad++; $display("FAIL b2b_out3: got %0d expected 9", n_out3); end
        n_cmp++;
        if (n_sf != 9) begin n_bad++; $display("FAIL b2b_filt: got %0d expected 9", n_sf); end
        n_cmp++;
        if (n_lbr != 1) begin n_bad++; $display("FAIL b2b_lbr: got %0d expected 1", n_lbr); end
        n_cmp++;
        if (n_done != 1) begin n_bad++; $display("FAIL b2b_done: got %0d expected 1", n_done); end
        n_cmp++;
        if (t_lastout != t_last + 2) begin
            n_bad++;
            $display("FAIL b2b_last_out: got %0d expected %0d", t_lastout, t_last + 2);
        end
        n_cmp++;
        if (t_done != t_last + 3) begin
            n_bad++;
            $display("FAIL b2b_done_time: got %0d expected %0d", t_done, t_last + 3);
        end
        n_cmp++;
        if (t_done3 != t_last + 5) begin
            n_bad++;
            $display("FAIL b2b_done3_time: got %0d expected %0d", t_done3, t_last + 5);
        end
        n_cmp++;
        if (n_err != 0) begin n_bad++; $display("FAIL b2b_cfg_err: got %0d expected 0", n_err); end
        n_cmp++;
        if (gap_viol != 0) begin n_bad++; $display("FAIL b2b_mac_align: got %0d expected 0", gap_viol); end
        @(posedge clk);
        #1;
        n_cmp++;
        if ({busy, busy3} !== 2'b00) begin
            n_bad++;
            $display("FAIL b2b_busy_after: got %b expected 00", {busy, busy3});
        end
    endtask

    task automatic test_toggle();
        run_job(4, 3, 1, 0, 0);
        n_cmp++;
        if (timeout) begin n_bad++; $display("FAIL tog_timeout: got 1 expected 0"); end
        n_cmp++;
        if (n_out != 2) begin n_bad++; $display("FAIL tog_out: got %0d expected 2", n_out); end
        n_cmp++;
        if (n_acc != 12) begin n_bad++; $display("FAIL tog_acc: got %0d expected 12", n_acc); end
        n_cmp++;
        if (gap_viol != 0) begin n_bad++; $display("FAIL tog_gap_mac: got %0d expected 0", gap_viol); end
        n_cmp++;
        if (n_done != 1) begin n_bad++; $display("FAIL tog_done: got %0d expected 1", n_done); end
    endtask

    task automatic test_cfg_err();
        run_job(2, 5, 0, 0, 0);
        n_cmp++;
        if (timeout) begin n_bad++; $display("FAIL cfg_timeout: got 1 expected 0"); end
        n_cmp++;
        if (n_errdone != 1) begin
            n_bad++;
            $display("FAIL cfg_err_done: got %0d expected 1", n_errdone);
        end
        n_cmp++;
        if (n_err != 1) begin n_bad++; $display("FAIL cfg_err_count: got %0d expected 1", n_err); end
        n_cmp++;
        if (n_sf != 0) begin n_bad++; $display("FAIL cfg_filt: got %0d expected 0", n_sf); end
        n_cmp++;
        if (n_out != 0) begin n_bad++; $display("FAIL cfg_out: got %0d expected 0", n_out); end
    endtask

    task automatic test_reset_mid_job();
        logic [9:0] o1;
        run_job(5, 5, 0, 0, 5);
        n_cmp++;
        if (!aborted) begin n_bad++; $display("FAIL rstmid_reached: got 0 expected 1"); end
        #1;
        o1 = {filt_ready, pix_ready, shifting_filter, shifting_line,
              line_buffer_reset, mac_enable, out_valid, busy, done, cfg_err};
        n_cmp++;
        if (o1 !== 10'b0) begin
            n_bad++;
            $display("FAIL rstmid_outputs: got %b expected 0", o1);
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        run_job(3, 3, 0, 0, 0);
        n_cmp++;
        if (n_out != 1) begin n_bad++; $display("FAIL rstmid_out: got %0d expected 1", n_out); end
        n_cmp++;
        if (n_sf != 9) begin n_bad++; $display("FAIL rstmid_filt: got %0d expected 9", n_sf); end
        n_cmp++;
        if (n_done != 1) begin n_bad++; $display("FAIL rstmid_done: got %0d expected 1", n_done); end
    endtask

    task automatic test_latency3();
        run_job(3, 4, 0, 0, 0);
        n_cmp++;
        if (n_out3 != 2) begin n_bad++; $display("FAIL lat3_out: got %0d expected 2", n_out3); end
        n_cmp++;
        if (lat_viol != 0) begin n_bad++; $display("FAIL lat3_align: got %0d expected 0", lat_viol); end
        n_cmp++;
        if (t_done3 != t_last + 5) begin
            n_bad++;
            $display("FAIL lat3_done_time: got %0d expected %0d", t_done3, t_last + 5);
        end
    endtask

    task automatic test_start_mid();
        run_job(4, 4, 0, 1, 0);
        n_cmp++;
        if (timeout) begin n_bad++; $display("FAIL mid_timeout: got 1 expected 0"); end
        n_cmp++;
        if (n_out != 4) begin n_bad++; $display("FAIL mid_out: got %0d expected 4", n_out); end
        n_cmp++;
        if (n_acc != 16) begin n_bad++; $display("FAIL mid_acc: got %0d expected 16", n_acc); end
        n_cmp++;
        if (n_sf != 9) begin n_bad++; $display("FAIL mid_filt: got %0d expected 9", n_sf); end
        n_cmp++;
        if (n_done != 1) begin n_bad++; $display("FAIL mid_done: got %0d expected 1", n_done); end
        n_cmp++;
        if (t_done != t_last + 3) begin
            n_bad++;
            $display("FAIL mid_done_time: got %0d expected %0d", t_done, t_last + 3);
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_toggle();
        test_cfg_err();
        test_reset_mid_job();
        test_latency3();
        test_start_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
